// File: rtl/psum_collector_if.sv
// psum_collector_if: the two streaming ports of the partial-sum collector.
//
// Handshake rules for the result side (R_*): a beat transfers on a rising
// edge where R_DataOutValid and R_DataOutRdy are both 1. Once valid is raised
// the data and last flag stay stable until that beat transfers. Valid never
// depends on ready in the same cycle.
//
// The PE side (PSum_*) cannot be back-pressured. PSum_DataInRdy is a credit
// grant: when it is 1 on an edge, the PE may issue, and the matching result
// shows up with PSum_DataInValid a fixed latency later. Valid is not qualified
// by ready on the cycle it arrives.
interface psum_collector_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] PSum_DataIn;
  logic                 PSum_DataInValid;
  logic                 PSum_DataInRdy;
  logic [DataWidth-1:0] R_DataOut;
  logic                 R_DataOutValid;
  logic                 R_DataOutRdy;
  logic                 R_DataOutLast;

  // Collector view: consumes the PE stream, produces the result stream.
  modport slave (
    input  PSum_DataIn,
    input  PSum_DataInValid,
    output PSum_DataInRdy,
    output R_DataOut,
    output R_DataOutValid,
    input  R_DataOutRdy,
    output R_DataOutLast
  );

  // Environment view: the PE plus the result writer.
  modport master (
    output PSum_DataIn,
    output PSum_DataInValid,
    input  PSum_DataInRdy,
    input  R_DataOut,
    input  R_DataOutValid,
    output R_DataOutRdy,
    input  R_DataOutLast
  );
endinterface

// File: rtl/psum_collector.sv
// psum_collector: captures the partial-sum stream of the last PE in a column,
// buffers it in a FIFO and re-emits it per tile with a last flag and a done
// pulse. PE issue permission is credit based: every granted issue cycle holds
// one credit for Latency cycles, so results already in the PE pipeline always
// have a FIFO slot waiting for them.
module psum_collector #(
  parameter int DataWidth  = 32,
  parameter int Latency    = 12,
  parameter int Depth      = 16,
  parameter int DepthWidth = 4
) (
  input  logic              clk,
  input  logic              aclr,
  psum_collector_if.slave   bus,
  input  logic [15:0]       TileCount,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [1:0]        dbg_state_o
);

  localparam int CountW = DepthWidth + 1;
  localparam int ResW   = $clog2(Latency + 1);
  localparam int SumW   = $clog2(Depth + Latency + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Control state and registered control outputs
  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] expected_q;

  // Tile progress counters
  logic [15:0] accepted_q, accepted_d;
  logic [15:0] emitted_q,  emitted_d;

  // Credit history: one bit per cycle, 1 where the PE was allowed to issue
  logic [Latency-1:0] hist_q, hist_d;

  // FIFO storage and bookkeeping
  logic [DataWidth-1:0]  mem_q [Depth];
  logic [DepthWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]     count_q,  count_d;

  logic overflow_q, overflow_d;

  // Combinational helpers
  logic [ResW-1:0]  reserved;
  logic [SumW-1:0]  credit_sum;
  logic             pe_rdy;
  logic             fifo_full;
  logic             r_valid;
  logic             push;
  logic             pop;
  logic             can_accept;
  logic             fault;
  logic             start_take;
  logic [15:0]      last_idx;
  logic             is_last;

  // Credits held by issues still travelling through the PE pipeline
  always_comb begin
    reserved = '0;
    for (int i = 0; i < Latency; i++) begin
      reserved = reserved + ResW'(hist_q[i]);
    end
  end

  // Issue permission and FIFO handshake decode; registered state only feeds
  // PSum_DataInRdy so the PE sees no same-cycle input dependence.
  always_comb begin
    credit_sum = SumW'(count_q) + SumW'(reserved);
    pe_rdy     = (state_q == S_COLLECT) && (credit_sum < SumW'(Depth));
    // count never exceeds Depth, so its top bit alone marks a full FIFO
    fifo_full  = count_q[DepthWidth];
    r_valid    = (count_q != '0);
    pop        = r_valid && bus.R_DataOutRdy;
    can_accept = (state_q == S_COLLECT) && (accepted_q < expected_q) && !fifo_full;
    push       = bus.PSum_DataInValid && can_accept;
    fault      = bus.PSum_DataInValid && !can_accept;
    start_take = (state_q == S_IDLE) && Start;
    last_idx   = expected_q - 16'd1;
    is_last    = (emitted_q == last_idx);
  end

  // Next-state for the datapath registers
  always_comb begin
    hist_d     = {hist_q[Latency-2:0], pe_rdy};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    emitted_d  = emitted_q;
    overflow_d = overflow_q | fault;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + DepthWidth'(1);
      accepted_d = accepted_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + DepthWidth'(1);
      emitted_d = emitted_q + 16'd1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase

    // A new tile starts from clean progress counters
    if (start_take) begin
      accepted_d = '0;
      emitted_d  = '0;
    end
  end

  // Tile control FSM with registered Busy/Done
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      expected_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            expected_q <= TileCount;
            busy_q     <= 1'b1;
            if (TileCount != 16'd0) begin
              state_q <= S_COLLECT;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (pop && is_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: pointers, occupancy, counters, credits, error flag
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      emitted_q  <= '0;
      hist_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      emitted_q  <= emitted_d;
      hist_q     <= hist_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because valid is gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.PSum_DataIn;
    end
  end

  // Output drive: everything comes from registers
  always_comb begin
    bus.PSum_DataInRdy = pe_rdy;
    bus.R_DataOutValid = r_valid;
    bus.R_DataOut      = r_valid ? mem_q[rd_ptr_q] : '0;
    bus.R_DataOutLast  = r_valid && is_last;
    Busy               = busy_q;
    Done               = done_q;
    Overflow           = overflow_q;
    dbg_state_o        = state_q;
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed bench for psum_collector with a fixed-latency
// PE model and an in-order scoreboard on the result stream.
module tb_psum_collector;

  localparam int DW    = 32;
  localparam int LAT   = 12;
  localparam int DEPTH = 16;
  localparam int W     = DW + 1;   // {last, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  psum_collector_if #(.DataWidth(DW)) bus ();
  logic [15:0] tile_count;
  logic        start;
  logic        busy, done, overflow;
  logic [1:0]  dbg_state;

  psum_collector #(
    .DataWidth (DW),
    .Latency   (LAT),
    .Depth     (DEPTH),
    .DepthWidth(4)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .bus        (bus),
    .TileCount  (tile_count),
    .Start      (start),
    .Busy       (busy),
    .Done       (done),
    .Overflow   (overflow),
    .dbg_state_o(dbg_state)
  );

  logic          r_rdy;
  logic          inj_v;
  logic [DW-1:0] inj_d;
  logic          pe_v = 1'b0;
  logic [DW-1:0] pe_d = '0;

  assign bus.PSum_DataInValid = pe_v | inj_v;
  assign bus.PSum_DataIn      = inj_v ? inj_d : pe_d;
  assign bus.R_DataOutRdy     = r_rdy;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pe_src_q[$];
  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int last_pop_edge = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- PE model ----------------
  // Issues one queued item on each edge where ready is high; the result
  // appears LAT edges later.
  logic          pipe_v [0:LAT] = '{default: 1'b0};
  logic [DW-1:0] pipe_d [0:LAT] = '{default: '0};

  always @(negedge clk) begin
    logic [W-1:0] item;
    for (int i = LAT; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = 1'b0;
    pipe_d[0] = '0;
    if (bus.PSum_DataInRdy === 1'b1 && pe_src_q.size() != 0) begin
      item = pe_src_q.pop_front();
      pipe_v[0] = 1'b1;
      pipe_d[0] = item[DW-1:0];
      exp_q.push_back(item);
    end
    pe_v = pipe_v[LAT];
    pe_d = pipe_d[LAT];
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] item;
    if (aclr === 1'b0 && bus.R_DataOutValid === 1'b1 && r_rdy === 1'b1) begin
      pop_cnt++;
      last_pop_edge = cyc + 1;
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        chk("r_data", 64'(bus.R_DataOut), 64'(item[DW-1:0]));
        chk("r_last", 64'(bus.R_DataOutLast), 64'(item[DW]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [15:0] n);
    tile_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_done_timing"}, 64'(cyc), 64'(last_pop_edge));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s_edge;
    int n;
    int rdy_cycles;
    int pc0;

    // Reset with random inputs and a Start in the same cycles
    aclr = 1'b1; start = 1'b1; tile_count = 16'd5;
    for (int i = 0; i < 2; i++) begin
      r_rdy = 1'($urandom_range(0, 1));
      inj_v = 1'($urandom_range(0, 1));
      inj_d = $urandom;
      tick();
    end
    chk("rst_pe_rdy",   64'(bus.PSum_DataInRdy), 64'd0);
    chk("rst_r_valid",  64'(bus.R_DataOutValid), 64'd0);
    chk("rst_r_last",   64'(bus.R_DataOutLast), 64'd0);
    chk("rst_r_data",   64'(bus.R_DataOut), 64'd0);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_done",     64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    aclr = 1'b0; start = 1'b0; inj_v = 1'b0; r_rdy = 1'b0;
    tick();
    chk("rst_start_ignored", 64'(busy), 64'd0);

    // Basic tile of three
    r_rdy = 1'b1;
    pe_src_q.push_back({1'b0, 32'd10});
    pe_src_q.push_back({1'b0, 32'd20});
    pe_src_q.push_back({1'b1, 32'd30});
    start_tile(16'd3);
    s_edge = cyc;
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_pe_rdy", 64'(bus.PSum_DataInRdy), 64'd1);
    n = 0;
    while (bus.R_DataOutValid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("basic_first_valid_latency", 64'(cyc - s_edge), 64'(LAT + 1));
    wait_done("basic", 40);
    tick();
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_overflow", 64'(overflow), 64'd0);

    // Zero-length tile, started in the first cycle IDLE is reached again
    start_tile(16'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_valid", 64'(bus.R_DataOutValid), 64'd0);
    tick();
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_busy_end", 64'(busy), 64'd0);
    chk("zero_valid_end", 64'(bus.R_DataOutValid), 64'd0);

    // Arrival while IDLE
    inj_v = 1'b1; inj_d = 32'hBAD0_0001;
    tick();
    inj_v = 1'b0;
    chk("idle_arrival_ovf", 64'(overflow), 64'd1);
    chk("idle_arrival_dropped", 64'(bus.R_DataOutValid), 64'd0);
    repeat (3) tick();
    chk("idle_ovf_sticky", 64'(overflow), 64'd1);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    chk("ovf_cleared_by_reset", 64'(overflow), 64'd0);

    // Extra arrival after the whole tile has been accepted
    r_rdy = 1'b0;
    pe_src_q.push_back({1'b0, 32'd11});
    pe_src_q.push_back({1'b0, 32'd22});
    pe_src_q.push_back({1'b1, 32'd33});
    start_tile(16'd3);
    repeat (20) tick();
    chk("extra_pre_ovf", 64'(overflow), 64'd0);
    chk("extra_pre_valid", 64'(bus.R_DataOutValid), 64'd1);
    inj_v = 1'b1; inj_d = 32'hDEAD_BEEF;
    tick();
    inj_v = 1'b0;
    chk("extra_arrival_ovf", 64'(overflow), 64'd1);
    r_rdy = 1'b1;
    wait_done("extra", 20);
    chk("extra_ovf_held", 64'(overflow), 64'd1);
    tick();
    chk("extra_dropped", 64'(bus.R_DataOutValid), 64'd0);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;

    // Credit limit: 40 results, writer stalled
    r_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pe_src_q.push_back({1'(i == 39), 32'($urandom)});
    end
    start_tile(16'd40);
    rdy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.PSum_DataInRdy === 1'b1) rdy_cycles++;
      tick();
    end
    chk("credit_rdy_cycles", 64'(rdy_cycles), 64'd16);
    chk("credit_rdy_low", 64'(bus.PSum_DataInRdy), 64'd0);
    chk("credit_no_ovf", 64'(overflow), 64'd0);
    chk("credit_valid", 64'(bus.R_DataOutValid), 64'd1);
    pc0 = pop_cnt;
    r_rdy = 1'b1;
    tick();
    tick();
    chk("credit_rdy_resume", 64'(bus.PSum_DataInRdy), 64'd1);
    repeat (14) tick();
    chk("credit_drain_rate", 64'(pop_cnt - pc0), 64'd16);
    wait_done("credit", 100);
    chk("credit_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("credit_end_ovf", 64'(overflow), 64'd0);
    tick();

    // Reset in the middle of a tile: 5 of 8 pushed, 2 popped
    r_rdy = 1'b0;
    start_tile(16'd8);
    for (int i = 0; i < 5; i++) begin
      inj_v = 1'b1;
      inj_d = 32'h100 + 32'(i);
      exp_q.push_back({1'b0, inj_d});
      tick();
    end
    inj_v = 1'b0;
    pc0 = pop_cnt;
    r_rdy = 1'b1;
    tick();
    tick();
    r_rdy = 1'b0;
    chk("mid_two_popped", 64'(pop_cnt - pc0), 64'd2);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 64'(bus.R_DataOutValid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_pe_rdy", 64'(bus.PSum_DataInRdy), 64'd0);
    r_rdy = 1'b1;
    pe_src_q.push_back({1'b0, 32'h5});
    pe_src_q.push_back({1'b1, 32'h6});
    start_tile(16'd2);
    wait_done("after_rst", 40);
    tick();
    chk("after_rst_idle", 64'(busy), 64'd0);
    chk("after_rst_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("after_rst_ovf", 64'(overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
